// File: rtl/pll_loop_ctrl_if.sv
// Signal bundle between the PLL loop-filter sequencer and its environment.
//   enable         : run request
//   cp_current     : signed charge-pump current sample
//   vctrl          : loop-filter control voltage (monitored only)
//   filter_reset   : drives the loop filter's reset
//   filter_current : signed current into the loop filter
//   locked         : high while locked
//   lost_lock      : one-cycle pulse on loss of lock
//   rail_fault     : one-cycle pulse on a railed-voltage restart
//   state          : current controller state code
// master drives the inputs (charge pump / test side), slave is the controller.
interface pll_loop_ctrl_if;
  logic               enable;
  logic signed [23:0] cp_current;
  logic        [9:0]  vctrl;
  logic               filter_reset;
  logic signed [23:0] filter_current;
  logic               locked;
  logic               lost_lock;
  logic               rail_fault;
  logic        [2:0]  state;

  modport master (
    output enable, cp_current, vctrl,
    input  filter_reset, filter_current, locked, lost_lock, rail_fault, state
  );

  modport slave (
    input  enable, cp_current, vctrl,
    output filter_reset, filter_current, locked, lost_lock, rail_fault, state
  );
endinterface

// File: rtl/pll_loop_ctrl.sv
// Sequencing controller for the PLL loop filter.
// Holds the filter in reset, then drives a gear-shifted (amplified) charge-pump
// current during acquisition, then passes it through unscaled for tracking.
// Lock is declared from the current magnitude; loss of lock returns to
// acquisition and a railed control voltage restarts from CLEAR.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : pll_loop_ctrl_if.slave (enable, cp_current, vctrl in;
//           filter_reset, filter_current, locked, lost_lock, rail_fault, state out)
module pll_loop_ctrl #(
  parameter int unsigned CLEAR_CYCLES  = 4,
  parameter int unsigned ACQ_SHIFT     = 3,
  parameter int unsigned ACQ_CYCLES    = 256,
  parameter int unsigned LOCK_THRESH   = 64,
  parameter int unsigned LOCK_COUNT    = 32,
  parameter int unsigned UNLOCK_THRESH = 512,
  parameter int unsigned UNLOCK_COUNT  = 8,
  parameter int unsigned RAIL_COUNT    = 16
) (
  input  logic           clk,
  input  logic           reset,
  pll_loop_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StClear   = 3'd1,
    StAcquire = 3'd2,
    StTrack   = 3'd3,
    StLocked  = 3'd4
  } state_e;

  localparam int unsigned PhMax = (CLEAR_CYCLES > ACQ_CYCLES) ? CLEAR_CYCLES : ACQ_CYCLES;
  localparam int unsigned PhW   = $clog2(PhMax + 1);
  localparam int unsigned WinW  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned OutW  = $clog2(UNLOCK_COUNT + 1);
  localparam int unsigned RailW = $clog2(RAIL_COUNT + 1);
  // One guard bit above the shifted value so overflow is visible in the top bits.
  localparam int unsigned WideW = 25 + ACQ_SHIFT;

  localparam logic [PhW-1:0]   ClearLast = PhW'(CLEAR_CYCLES - 1);
  localparam logic [PhW-1:0]   AcqLast   = PhW'(ACQ_CYCLES - 1);
  localparam logic [WinW-1:0]  WinLast   = WinW'(LOCK_COUNT - 1);
  localparam logic [OutW-1:0]  OutLast   = OutW'(UNLOCK_COUNT - 1);
  localparam logic [RailW-1:0] RailLast  = RailW'(RAIL_COUNT - 1);
  localparam logic [23:0]      LockThr   = 24'(LOCK_THRESH);
  localparam logic [23:0]      UnlockThr = 24'(UNLOCK_THRESH);

  state_e             state_q, state_d;
  logic [PhW-1:0]     ph_q, ph_d;
  logic [WinW-1:0]    win_q, win_d;
  logic [OutW-1:0]    out_q, out_d;
  logic [RailW-1:0]   rail_q, rail_d;
  logic               lost_q, lost_d;
  logic               fault_q, fault_d;
  logic signed [23:0] fc_q, fc_d;

  // Magnitude as unsigned so that -2^23 maps to 2^23 without overflow.
  logic [23:0] cp_u;
  logic [23:0] mag;
  logic        in_win;
  logic        out_win;
  logic        rail_hit;
  logic        monitoring;
  logic        rail_done;

  assign cp_u       = bus.cp_current;
  assign mag        = cp_u[23] ? (~cp_u + 24'd1) : cp_u;
  assign in_win     = (mag <= LockThr);
  assign out_win    = (mag > UnlockThr);
  assign rail_hit   = (bus.vctrl == 10'd0) || (bus.vctrl == 10'd1023);
  assign monitoring = (state_q == StTrack) || (state_q == StLocked);
  assign rail_done  = monitoring && rail_hit && (rail_q >= RailLast);

  // Gear-shifted current with saturation to the 24-bit signed range.
  logic signed [WideW-1:0] cp_wide;
  logic signed [WideW-1:0] cp_shifted;
  logic                    pos_ovf;
  logic                    neg_ovf;
  logic signed [23:0]      cp_gear;

  assign cp_wide    = WideW'(bus.cp_current);
  assign cp_shifted = cp_wide <<< ACQ_SHIFT;
  assign pos_ovf    = !cp_shifted[WideW-1] && (|cp_shifted[WideW-2:23]);
  assign neg_ovf    = cp_shifted[WideW-1] && !(&cp_shifted[WideW-2:23]);

  always_comb begin
    cp_gear = cp_shifted[23:0];
    if (pos_ovf) begin
      cp_gear = 24'sh7fffff;
    end else if (neg_ovf) begin
      cp_gear = 24'sh800000;
    end
  end

  // Every counter stops at its terminal value because reaching it forces a
  // transition that clears it, so none can wrap.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    win_d   = '0;
    out_d   = '0;
    rail_d  = '0;
    lost_d  = 1'b0;
    fault_d = 1'b0;

    if (monitoring && rail_hit) begin
      rail_d = (rail_q >= RailLast) ? rail_q : rail_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        ph_d = '0;
        if (bus.enable) begin
          state_d = StClear;
        end
      end
      StClear: begin
        if (ph_q >= ClearLast) begin
          state_d = StAcquire;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      StAcquire: begin
        if (ph_q >= AcqLast) begin
          state_d = StTrack;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      StTrack: begin
        // The sample that completes the run triggers the lock.
        if (in_win) begin
          if (win_q >= WinLast) begin
            state_d = StLocked;
          end else begin
            win_d = win_q + 1'b1;
          end
        end
      end
      StLocked: begin
        if (out_win) begin
          if (out_q >= OutLast) begin
            state_d = StAcquire;
            ph_d    = '0;
            lost_d  = 1'b1;
          end else begin
            out_d = out_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        ph_d    = '0;
      end
    endcase

    // Rail restart outranks the state-specific transition (including unlock).
    if (rail_done) begin
      state_d = StClear;
      ph_d    = '0;
      win_d   = '0;
      out_d   = '0;
      rail_d  = '0;
      lost_d  = 1'b0;
      fault_d = 1'b1;
    end

    // Dropping enable outranks everything and suppresses both pulses.
    if (!bus.enable) begin
      state_d = StIdle;
      ph_d    = '0;
      win_d   = '0;
      out_d   = '0;
      rail_d  = '0;
      lost_d  = 1'b0;
      fault_d = 1'b0;
    end

    // Scaling follows the state being entered on this edge.
    case (state_d)
      StAcquire:         fc_d = cp_gear;
      StTrack, StLocked: fc_d = bus.cp_current;
      default:           fc_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ph_q    <= '0;
      win_q   <= '0;
      out_q   <= '0;
      rail_q  <= '0;
      lost_q  <= 1'b0;
      fault_q <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      win_q   <= win_d;
      out_q   <= out_d;
      rail_q  <= rail_d;
      lost_q  <= lost_d;
      fault_q <= fault_d;
      fc_q    <= fc_d;
    end
  end

  assign bus.state          = state_q;
  assign bus.filter_reset   = (state_q == StIdle) || (state_q == StClear);
  assign bus.locked         = (state_q == StLocked);
  assign bus.lost_lock      = lost_q;
  assign bus.rail_fault     = fault_q;
  assign bus.filter_current = fc_q;

endmodule

// File: tb/tb_pll_loop_ctrl.sv
// Self-checking bench for pll_loop_ctrl: directed sequences plus randomized
// stimulus, with a reference model feeding an expectation queue that a
// separate monitor drains every clock.
module tb_pll_loop_ctrl;
  localparam int CLR  = 4;
  localparam int SH   = 3;
  localparam int ACQ  = 256;
  localparam int LTH  = 64;
  localparam int LCNT = 32;
  localparam int UTH  = 512;
  localparam int UCNT = 8;
  localparam int RCNT = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pll_loop_ctrl_if bus ();

  pll_loop_ctrl #(
    .CLEAR_CYCLES (CLR),
    .ACQ_SHIFT    (SH),
    .ACQ_CYCLES   (ACQ),
    .LOCK_THRESH  (LTH),
    .LOCK_COUNT   (LCNT),
    .UNLOCK_THRESH(UTH),
    .UNLOCK_COUNT (UCNT),
    .RAIL_COUNT   (RCNT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     st;
    bit     fr;
    bit     lk;
    bit     ll;
    bit     rf;
    longint fc;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: state number, time spent in state, and current run lengths.
  int m_st, m_age, m_win, m_out, m_rail;

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_age = 0; m_win = 0; m_out = 0; m_rail = 0;
  endtask

  task automatic model_step(bit en, int cp, int vc);
    longint mag, fc;
    int nst, rail_run, win_run, out_run;
    bit lost, fault;
    exp_t e;
    lost  = 1'b0;
    fault = 1'b0;
    mag = (cp < 0) ? -longint'(cp) : longint'(cp);
    rail_run = ((m_st == 3 || m_st == 4) && (vc == 0 || vc == 1023)) ? m_rail + 1 : 0;
    win_run  = (m_st == 3 && mag <= LTH) ? m_win + 1 : 0;
    out_run  = (m_st == 4 && mag > UTH) ? m_out + 1 : 0;
    nst = m_st;
    if (!en) nst = 0;
    else if (rail_run >= RCNT) begin
      nst = 1;
      fault = 1'b1;
    end else begin
      case (m_st)
        0: nst = 1;
        1: if (m_age + 1 >= CLR) nst = 2;
        2: if (m_age + 1 >= ACQ) nst = 3;
        3: if (win_run >= LCNT) nst = 4;
        4: if (out_run >= UCNT) begin nst = 2; lost = 1'b1; end
        default: nst = 0;
      endcase
    end
    if (nst != m_st) begin
      m_age = 0;
      m_win = 0;
    end else begin
      m_age++;
      m_win = win_run;
    end
    m_out  = (nst == 4) ? out_run : 0;
    m_rail = (nst == 3 || nst == 4) ? rail_run : 0;
    m_st   = nst;
    if (nst == 2) begin
      fc = longint'(cp) * (longint'(1) << SH);
      if (fc > 8388607) fc = 8388607;
      if (fc < -8388608) fc = -8388608;
    end else if (nst >= 3) fc = cp;
    else fc = 0;
    e.st = nst;
    e.fr = (nst <= 1);
    e.lk = (nst == 4);
    e.ll = lost;
    e.rf = fault;
    e.fc = fc;
    exp_q.push_back(e);
  endtask

  task automatic step(bit en, int cp, int vc);
    @(negedge clk);
    bus.enable     = en;
    bus.cp_current = 24'(cp);
    bus.vctrl      = 10'(vc);
    model_step(en, cp, vc);
    @(posedge clk);
    #2;
  endtask

  task automatic run_until(int target, int cp, int vc, int limit);
    int n = 0;
    while (m_st != target && n < limit) begin
      step(1'b1, cp, vc);
      n++;
    end
    chk($sformatf("reach state %0d", target), bus.state, target);
  endtask

  // Monitor: compares every registered output once per clock while expectations remain.
  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc++;
      chk($sformatf("c%0d state", cyc), bus.state, e.st);
      chk($sformatf("c%0d filter_reset", cyc), bus.filter_reset, e.fr);
      chk($sformatf("c%0d locked", cyc), bus.locked, e.lk);
      chk($sformatf("c%0d lost_lock", cyc), bus.lost_lock, e.ll);
      chk($sformatf("c%0d rail_fault", cyc), bus.rail_fault, e.rf);
      chk($sformatf("c%0d filter_current", cyc), longint'($signed(bus.filter_current)), e.fc);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bnd[11];
    int seg, cp_mode, vc_mode, cp, vc;
    bit en;
    bnd = '{64, 65, -64, -65, 512, 513, -512, -513, -8388608, 8388607, 1048576};
    seg = 0; cp_mode = 0; vc_mode = 0;

    // Reset and enable
    bus.enable = 1'b1; bus.cp_current = '0; bus.vctrl = 10'd500;
    reset = 1'b1;
    #12;
    chk("reset filter_reset", bus.filter_reset, 1);
    chk("reset state", bus.state, 0);
    chk("reset filter_current", longint'($signed(bus.filter_current)), 0);
    chk("reset locked", bus.locked, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    chk("release state", bus.state, 0);
    chk("release filter_reset", bus.filter_reset, 1);
    model_step(1'b1, 0, 500);
    @(posedge clk);
    #2;
    chk("enable -> clear", bus.state, 1);
    repeat (3) step(1'b1, 0, 500);
    chk("clear held", bus.state, 1);
    chk("clear filter_reset", bus.filter_reset, 1);

    // Gear shift in ACQUIRE
    step(1'b1, 1000, 500);
    chk("acquire state", bus.state, 2);
    chk("acquire filter_reset", bus.filter_reset, 0);
    chk("gear 1000", longint'($signed(bus.filter_current)), 8000);
    step(1'b1, 4194304, 500);
    chk("gear sat pos", longint'($signed(bus.filter_current)), 8388607);
    step(1'b1, -8388608, 500);
    chk("gear sat neg", longint'($signed(bus.filter_current)), -8388608);
    run_until(3, 0, 500, 300);
    step(1'b1, 1000, 500);
    chk("track passthrough", longint'($signed(bus.filter_current)), 1000);

    // Lock acquisition
    repeat (31) step(1'b1, 50, 500);
    step(1'b1, 100, 500);
    repeat (31) step(1'b1, 50, 500);
    chk("lock not early", bus.locked, 0);
    step(1'b1, 50, 500);
    chk("lock reached", bus.locked, 1);
    chk("locked state", bus.state, 4);

    // Loss of lock
    repeat (7) step(1'b1, 600, 500);
    step(1'b1, 0, 500);
    repeat (7) step(1'b1, 600, 500);
    chk("unlock not early", bus.locked, 1);
    step(1'b1, 600, 500);
    chk("lost_lock pulse", bus.lost_lock, 1);
    chk("unlock state", bus.state, 2);
    chk("unlock locked", bus.locked, 0);
    step(1'b1, 0, 500);
    chk("lost_lock one cycle", bus.lost_lock, 0);

    // Rail restart from LOCKED
    run_until(3, 0, 500, 300);
    repeat (32) step(1'b1, 0, 500);
    chk("relock", bus.locked, 1);
    repeat (15) step(1'b1, 0, 1023);
    chk("rail not early", bus.state, 4);
    step(1'b1, 0, 1023);
    chk("rail_fault pulse", bus.rail_fault, 1);
    chk("rail state", bus.state, 1);
    chk("rail filter_reset", bus.filter_reset, 1);
    step(1'b1, 0, 500);
    chk("rail_fault one cycle", bus.rail_fault, 0);

    // Near-miss rail run in TRACK
    run_until(3, 0, 500, 300);
    repeat (15) step(1'b1, 1000, 0);
    step(1'b1, 1000, 500);
    chk("rail near miss state", bus.state, 3);
    chk("rail near miss pulse", bus.rail_fault, 0);

    // Rail and unlock completing together: rail wins
    repeat (32) step(1'b1, 0, 500);
    chk("lock for tie", bus.locked, 1);
    repeat (8) step(1'b1, 0, 1023);
    repeat (7) step(1'b1, 600, 1023);
    step(1'b1, 600, 1023);
    chk("tie rail_fault", bus.rail_fault, 1);
    chk("tie lost_lock", bus.lost_lock, 0);
    chk("tie state", bus.state, 1);

    // enable low on the same edge as rail and unlock events
    run_until(3, 0, 500, 300);
    repeat (32) step(1'b1, 0, 500);
    repeat (8) step(1'b1, 0, 1023);
    repeat (7) step(1'b1, 600, 1023);
    step(1'b0, 600, 1023);
    chk("disable beats events state", bus.state, 0);
    chk("disable no rail_fault", bus.rail_fault, 0);
    chk("disable no lost_lock", bus.lost_lock, 0);

    // Abort mid-ACQUIRE
    run_until(2, 0, 500, 20);
    repeat (100) step(1'b1, 777, 500);
    step(1'b0, 777, 500);
    chk("abort state", bus.state, 0);
    chk("abort filter_current", longint'($signed(bus.filter_current)), 0);

    // Asynchronous reset mid-TRACK
    run_until(3, 0, 500, 300);
    step(1'b1, 1000, 500);
    #1;
    reset = 1'b1;
    bus.enable = 1'b0;
    #1;
    chk("async state", bus.state, 0);
    chk("async filter_reset", bus.filter_reset, 1);
    chk("async filter_current", longint'($signed(bus.filter_current)), 0);
    chk("async locked", bus.locked, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Randomized segments
    for (int i = 0; i < 5000; i++) begin
      if (seg == 0) begin
        seg     = $urandom_range(10, 60);
        cp_mode = $urandom_range(0, 3);
        vc_mode = $urandom_range(0, 3);
      end
      seg--;
      en = ($urandom_range(0, 599) != 0);
      case (cp_mode)
        0: cp = int'($urandom_range(0, 128)) - 64;
        1: begin
          cp = int'($urandom_range(513, 8388607));
          if ($urandom_range(0, 1) == 1) cp = -cp;
        end
        2: cp = int'($signed(24'($urandom)));
        default: cp = bnd[$urandom_range(0, 10)];
      endcase
      if (vc_mode == 0) vc = ($urandom_range(0, 1) == 1) ? 1023 : 0;
      else if ($urandom_range(0, 19) == 0) vc = 1023;
      else vc = int'($urandom_range(1, 1022));
      step(en, cp, vc);
    end

    repeat (3) @(posedge clk);
    chk("queue drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
